// File: rtl/ofs_fim_eth_if_pkg.sv
// Ethernet AXIS types shared between the MAC-facing RX path and the AFU.
// The beat type is the stream payload without tvalid, as stored in the RX buffer RAM.
package ofs_fim_eth_if_pkg;

  localparam int ETH_DATA_WIDTH = 64;
  localparam int ETH_KEEP_WIDTH = ETH_DATA_WIDTH / 8;
  localparam int ETH_USER_WIDTH = 8;

  typedef struct packed {
    logic                      tvalid;
    logic                      tlast;
    logic [ETH_DATA_WIDTH-1:0] tdata;
    logic [ETH_KEEP_WIDTH-1:0] tkeep;
    logic [ETH_USER_WIDTH-1:0] tuser;
  } t_axis_eth_rx;

  localparam int AXIS_ETH_RX_WIDTH = $bits(t_axis_eth_rx);

  typedef struct packed {
    logic                      tlast;
    logic [ETH_DATA_WIDTH-1:0] tdata;
    logic [ETH_KEEP_WIDTH-1:0] tkeep;
    logic [ETH_USER_WIDTH-1:0] tuser;
  } t_axis_eth_rx_beat;

  localparam int ETH_RX_BEAT_WIDTH = $bits(t_axis_eth_rx_beat);

  function automatic t_axis_eth_rx_beat eth_rx_to_beat(input t_axis_eth_rx s);
    t_axis_eth_rx_beat b;
    b.tlast = s.tlast;
    b.tdata = s.tdata;
    b.tkeep = s.tkeep;
    b.tuser = s.tuser;
    return b;
  endfunction

endpackage

// File: rtl/ofs_fim_eth_rx_buf_ram.sv
// Simple dual-port RAM holding buffered RX beats.
// It has one write port and one read port; the read port has a 1-cycle registered output that holds while rd_en is low.
module ofs_fim_eth_rx_buf_ram
  import ofs_fim_eth_if_pkg::*;
#(
  parameter int WIDTH      = ETH_RX_BEAT_WIDTH,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ofs_fim_eth_rx_ovf_drop_buf.sv
// Store-and-forward RX buffer. It accepts MAC beats that cannot be throttled and drops any packet that does not fit.
// Only fully committed packets are presented to the AFU, on a ready/valid stream.
module ofs_fim_eth_rx_ovf_drop_buf
  import ofs_fim_eth_if_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  t_axis_eth_rx         i_rx,
  output t_axis_eth_rx         o_rx,
  input  logic                 i_rx_tready,
  output logic                 o_drop_pulse,
  output logic [CNT_WIDTH-1:0] o_drop_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, WRITING, DROPPING} t_wr_state;

  t_wr_state              wr_state;
  logic [PTR_W-1:0]       wr_ptr, commit_ptr, rd_ptr, fetch_ptr;
  logic                   full, wr_en, rd_en;
  logic                   ram_valid, ram_move, out_valid, out_pop;
  logic [ETH_RX_BEAT_WIDTH-1:0] ram_q;
  t_axis_eth_rx_beat      in_beat, out_beat;
  logic                   drop_pulse;
  logic [CNT_WIDTH-1:0]   drop_cnt;

  // rd_ptr frees a slot only when the AFU takes the beat, so prefetched beats still occupy space.
  assign full    = (wr_ptr - rd_ptr) == PTR_W'(DEPTH);
  assign wr_en   = i_rx.tvalid && !full && (wr_state != DROPPING);
  assign in_beat = eth_rx_to_beat(i_rx);

  assign out_pop  = out_valid && i_rx_tready;
  assign ram_move = ram_valid && (!out_valid || out_pop);
  assign rd_en    = (fetch_ptr != commit_ptr) && (!ram_valid || ram_move);

  ofs_fim_eth_rx_buf_ram #(
    .WIDTH      (ETH_RX_BEAT_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) buf_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[DEPTH_LOG2-1:0]),
    .wr_data (in_beat),
    .rd_en   (rd_en),
    .rd_addr (fetch_ptr[DEPTH_LOG2-1:0]),
    .rd_data (ram_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state   <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      drop_pulse <= 1'b0;
      if (i_rx.tvalid) begin
        case (wr_state)
          IDLE, WRITING: begin
            if (!full) begin
              wr_ptr <= wr_ptr + 1'b1;
              if (i_rx.tlast) begin
                commit_ptr <= wr_ptr + 1'b1;
                wr_state   <= IDLE;
              end else begin
                wr_state <= WRITING;
              end
            end else begin
              // Rewinding to the commit point discards the partial packet and leaves committed data intact.
              wr_ptr     <= commit_ptr;
              drop_pulse <= 1'b1;
              if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
              wr_state   <= i_rx.tlast ? IDLE : DROPPING;
            end
          end
          DROPPING: if (i_rx.tlast) wr_state <= IDLE;
          default: wr_state <= IDLE;
        endcase
      end
    end
  end

  // The RAM output register and the output register form a two-stage prefetch pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_ptr <= '0;
      rd_ptr    <= '0;
      ram_valid <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (rd_en) fetch_ptr <= fetch_ptr + 1'b1;
      if (out_pop) rd_ptr <= rd_ptr + 1'b1;
      if (rd_en) ram_valid <= 1'b1;
      else if (ram_move) ram_valid <= 1'b0;
      if (ram_move) out_valid <= 1'b1;
      else if (out_pop) out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_move) out_beat <= t_axis_eth_rx_beat'(ram_q);
  end

  always_comb begin
    o_rx        = '0;
    o_rx.tvalid = out_valid;
    o_rx.tlast  = out_beat.tlast;
    o_rx.tdata  = out_beat.tdata;
    o_rx.tkeep  = out_beat.tkeep;
    o_rx.tuser  = out_beat.tuser;
  end

  assign o_drop_pulse = drop_pulse;
  assign o_drop_cnt   = drop_cnt;

endmodule

// File: tb/tb_ofs_fim_eth_rx_ovf_drop_buf.sv
// Directed bench for the RX overflow-drop buffer, using a small 16-beat buffer and a 3-bit drop counter.
// A scoreboard queue holds the beats each test expects the AFU to receive.
`timescale 1ns/1ps
module tb_ofs_fim_eth_rx_ovf_drop_buf;
  import ofs_fim_eth_if_pkg::*;

  localparam int DEPTH_LOG2 = 4;
  localparam int CNT_WIDTH  = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  t_axis_eth_rx         i_rx = '0;
  t_axis_eth_rx         o_rx;
  logic                 i_rx_tready = 1'b0;
  logic                 o_drop_pulse;
  logic [CNT_WIDTH-1:0] o_drop_cnt;

  int checks = 0;
  int errors = 0;
  int pulseCount = 0;
  int treadyMode = 0;
  int pulseBase = 0;
  t_axis_eth_rx_beat expQ[$];
  logic stallSeen = 1'b0;
  t_axis_eth_rx_beat stallBeat;

  always #5 clk = ~clk;

  ofs_fim_eth_rx_ovf_drop_buf #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_rx         (i_rx),
    .o_rx         (o_rx),
    .i_rx_tready  (i_rx_tready),
    .o_drop_pulse (o_drop_pulse),
    .o_drop_cnt   (o_drop_cnt)
  );

  // AFU ready is driven one step after each rising edge: 0 = stalled, 1 = always ready, 2 = random.
  always @(posedge clk) begin
    #1;
    case (treadyMode)
      0: i_rx_tready = 1'b0;
      1: i_rx_tready = 1'b1;
      default: i_rx_tready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // The monitor matches every accepted beat against the scoreboard and checks that a stalled beat holds.
  always @(negedge clk) begin
    if (rst) begin
      stallSeen = 1'b0;
    end else begin
      if (stallSeen) begin
        checkOutput("stall tvalid held", o_rx.tvalid, 1'b1);
        checkOutput("stall beat held", eth_rx_to_beat(o_rx), stallBeat);
      end
      if (o_rx.tvalid && i_rx_tready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected beat", o_rx.tvalid, 1'b0);
        end else begin
          checkOutput("beat contents", eth_rx_to_beat(o_rx), expQ[0]);
          void'(expQ.pop_front());
        end
      end
      stallSeen = o_rx.tvalid && !i_rx_tready;
      stallBeat = eth_rx_to_beat(o_rx);
      if (o_drop_pulse) pulseCount++;
    end
  end

  function automatic t_axis_eth_rx_beat makeBeat(input int id, input int idx, input int len);
    t_axis_eth_rx_beat b;
    b.tlast = (idx == len - 1);
    b.tdata = {16'(id), 16'hA5C3, 32'(idx)};
    b.tkeep = b.tlast ? 8'(8'hFF >> (id % 8)) : 8'hFF;
    b.tuser = 8'(id * 7 + idx);
    return b;
  endfunction

  task automatic syncDrive();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input t_axis_eth_rx_beat b);
    i_rx.tvalid = 1'b1;
    i_rx.tlast  = b.tlast;
    i_rx.tdata  = b.tdata;
    i_rx.tkeep  = b.tkeep;
    i_rx.tuser  = b.tuser;
    syncDrive();
  endtask

  task automatic sendPacket(input int id, input int len, input bit deliver);
    if (deliver)
      for (int i = 0; i < len; i++) expQ.push_back(makeBeat(id, i, len));
    for (int i = 0; i < len; i++) applyStimulus(makeBeat(id, i, len));
    i_rx.tvalid = 1'b0;
  endtask

  task automatic waitDrain(input string tag, input int budget);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (expQ.size() != 0 && n < budget);
    #1;
    checkOutput(tag, expQ.size(), 0);
    repeat (3) syncDrive();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) syncDrive();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset tvalid", o_rx.tvalid, 1'b0);
    checkOutput("reset drop_cnt", o_drop_cnt, 3'd0);
    checkOutput("reset drop_pulse", o_drop_pulse, 1'b0);

    $display("[TB] T1 single 4-beat packet, latency");
    treadyMode = 1;
    repeat (2) syncDrive();
    sendPacket(1, 4, 1'b1);
    @(negedge clk);
    checkOutput("T1 tvalid +1", o_rx.tvalid, 1'b0);
    @(negedge clk);
    checkOutput("T1 tvalid +2", o_rx.tvalid, 1'b0);
    @(negedge clk);
    checkOutput("T1 tvalid +3", o_rx.tvalid, 1'b1);
    waitDrain("T1 drain", 50);
    checkOutput("T1 drop_cnt", o_drop_cnt, 3'd0);

    $display("[TB] T2 fill with two packets, third dropped");
    treadyMode = 0;
    repeat (2) syncDrive();
    pulseBase = pulseCount;
    sendPacket(10, 8, 1'b1);
    sendPacket(11, 8, 1'b1);
    sendPacket(12, 8, 1'b0);
    repeat (3) syncDrive();
    checkOutput("T2 drop_cnt", o_drop_cnt, 3'd1);
    checkOutput("T2 drop pulses", pulseCount - pulseBase, 1);
    checkOutput("T2 stalled tvalid", o_rx.tvalid, 1'b1);
    treadyMode = 1;
    waitDrain("T2 drain", 100);

    $display("[TB] T3 oversize packet then short packet");
    sendPacket(20, 17, 1'b0);
    repeat (2) syncDrive();
    checkOutput("T3 drop_cnt", o_drop_cnt, 3'd2);
    sendPacket(21, 2, 1'b1);
    waitDrain("T3 drain", 50);

    $display("[TB] T4 random ready, random lengths");
    treadyMode = 2;
    pulseBase = pulseCount;
    for (int p = 0; p < 40; p++) begin
      sendPacket(100 + p, int'($urandom_range(1, 16)), 1'b1);
      waitDrain("T4 drain", 300);
    end
    checkOutput("T4 drop_cnt", o_drop_cnt, 3'd2);
    checkOutput("T4 no pulses", pulseCount - pulseBase, 0);

    $display("[TB] T5 reset with buffered data");
    treadyMode = 0;
    repeat (2) syncDrive();
    sendPacket(30, 3, 1'b1);
    sendPacket(31, 3, 1'b1);
    applyStimulus(makeBeat(32, 0, 4));
    applyStimulus(makeBeat(32, 1, 4));
    i_rx.tvalid = 1'b0;
    rst = 1'b1;
    expQ.delete();
    syncDrive();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("T5 tvalid after reset", o_rx.tvalid, 1'b0);
    checkOutput("T5 drop_cnt after reset", o_drop_cnt, 3'd0);
    treadyMode = 1;
    syncDrive();
    sendPacket(33, 5, 1'b1);
    waitDrain("T5 drain", 50);
    repeat (10) syncDrive();

    $display("[TB] T6 drop counter saturation");
    for (int i = 0; i < 7; i++) sendPacket(40 + i, 17, 1'b0);
    syncDrive();
    checkOutput("T6 drop_cnt at max", o_drop_cnt, 3'd7);
    pulseBase = pulseCount;
    sendPacket(50, 17, 1'b0);
    repeat (2) syncDrive();
    checkOutput("T6 drop_cnt saturated", o_drop_cnt, 3'd7);
    checkOutput("T6 pulse on saturated drop", pulseCount - pulseBase, 1);
    sendPacket(51, 3, 1'b1);
    waitDrain("T6 drain", 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
